vt_write_arbiter: RTL and testbench

Owns the shared runtime write port of the variable table cluster. It arbitrates variable-flip write requests from NUM_REQ flip units and drives one synchronous write per cycle. The address is replicated to every table so all copies stay coherent. It also runs a per-thread clear sweep that zeroes every variable of one thread, and it holds off all writes while the clause evaluators are reading.

---
 rtl/vt_write_arbiter.sv | 166 ++++++++++++++++
 tb/tb_vt_write_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vt_write_arbiter.sv
// Runtime write-port owner for the variable table cluster: round-robin flip-unit
// arbitration, per-thread clear sweep, and read hold-off, driving one registered write per cycle.
module vt_write_arbiter #(
    parameter int VARIABLE_ADDRESS_WIDTH = 11,
    parameter int THREAD_ID_WIDTH        = 4,
    parameter int CLUSTER_SIZE           = 40,
    parameter int NUM_REQ                = 4
) (
    input  logic                                                     clk_i,
    input  logic                                                     rst_ni,
    input  logic [NUM_REQ-1:0]                                       req_valid_i,
    output logic [NUM_REQ-1:0]                                       req_ready_o,
    input  logic [NUM_REQ*THREAD_ID_WIDTH-1:0]                       req_thread_mi,
    input  logic [NUM_REQ*VARIABLE_ADDRESS_WIDTH-1:0]                req_var_mi,
    input  logic [NUM_REQ-1:0]                                       req_data_i,
    input  logic                                                     rd_busy_i,
    input  logic                                                     clear_start_i,
    input  logic [THREAD_ID_WIDTH-1:0]                               clear_thread_i,
    output logic                                                     clear_busy_o,
    output logic                                                     clear_done_o,
    output logic                                                     vt_en_o,
    output logic                                                     vt_wr_en_o,
    output logic [CLUSTER_SIZE*(THREAD_ID_WIDTH+VARIABLE_ADDRESS_WIDTH)-1:0] vt_addr_mo,
    output logic                                                     vt_data_o,
    output logic [NUM_REQ-1:0]                                       wr_ack_o
);

    localparam int AW    = THREAD_ID_WIDTH + VARIABLE_ADDRESS_WIDTH;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = VARIABLE_ADDRESS_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(1) << VARIABLE_ADDRESS_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                       state_reg, state_next;
    logic [PTR_W-1:0]             rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]             cnt_reg, cnt_next;
    logic [THREAD_ID_WIDTH-1:0]   clear_thread_reg, clear_thread_next;
    logic                         vt_en_reg, vt_en_next;
    logic [AW-1:0]                vt_addr_reg, vt_addr_next;
    logic                         vt_data_reg, vt_data_next;
    logic [NUM_REQ-1:0]           wr_ack_reg, wr_ack_next;
    logic                         clear_done_reg, clear_done_next;

    logic [THREAD_ID_WIDTH-1:0]       req_thread [NUM_REQ];
    logic [VARIABLE_ADDRESS_WIDTH-1:0] req_var   [NUM_REQ];
    logic                             grant_found;
    logic [PTR_W-1:0]                 grant_idx;
    logic [PTR_W:0]                   rot_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_thread[gi] = req_thread_mi[gi*THREAD_ID_WIDTH +: THREAD_ID_WIDTH];
            assign req_var[gi]    = req_var_mi[gi*VARIABLE_ADDRESS_WIDTH +: VARIABLE_ADDRESS_WIDTH];
        end
        for (gi = 0; gi < CLUSTER_SIZE; gi++) begin : g_addr_rep
            assign vt_addr_mo[gi*AW +: AW] = vt_addr_reg;
        end
    endgenerate

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rot_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rot_idx = {1'b0, rr_ptr_reg} + (PTR_W+1)'(k);
            if (rot_idx >= (PTR_W+1)'(NUM_REQ)) begin
                rot_idx = rot_idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid_i[rot_idx[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = rot_idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_next        = state_reg;
        rr_ptr_next       = rr_ptr_reg;
        cnt_next          = cnt_reg;
        clear_thread_next = clear_thread_reg;
        vt_en_next        = 1'b0;
        vt_addr_next      = vt_addr_reg;
        vt_data_next      = vt_data_reg;
        wr_ack_next       = '0;
        clear_done_next   = 1'b0;
        req_ready_o       = '0;

        case (state_reg)
            IDLE: begin
                if (!rd_busy_i) begin
                    if (clear_start_i) begin
                        clear_thread_next = clear_thread_i;
                        cnt_next          = '0;
                        state_next        = CLEAR;
                    end else if (grant_found) begin
                        req_ready_o[grant_idx] = 1'b1;
                        wr_ack_next[grant_idx] = 1'b1;
                        vt_en_next             = 1'b1;
                        vt_addr_next           = {req_thread[grant_idx], req_var[grant_idx]};
                        vt_data_next           = req_data_i[grant_idx];
                        rr_ptr_next            = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0
                                               : grant_idx + PTR_W'(1);
                    end
                end
            end
            CLEAR: begin
                if (!rd_busy_i) begin
                    vt_en_next   = 1'b1;
                    vt_addr_next = {clear_thread_reg, cnt_reg[VARIABLE_ADDRESS_WIDTH-1:0]};
                    vt_data_next = 1'b0;
                    cnt_next     = cnt_reg + CNT_W'(1);
                    // The extra counter bit lets the last index be detected without wrapping.
                    if (cnt_next == CNT_END) begin
                        state_next      = DONE;
                        clear_done_next = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg        <= IDLE;
            rr_ptr_reg       <= '0;
            cnt_reg          <= '0;
            clear_thread_reg <= '0;
            vt_en_reg        <= 1'b0;
            vt_addr_reg      <= '0;
            vt_data_reg      <= 1'b0;
            wr_ack_reg       <= '0;
            clear_done_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            rr_ptr_reg       <= rr_ptr_next;
            cnt_reg          <= cnt_next;
            clear_thread_reg <= clear_thread_next;
            vt_en_reg        <= vt_en_next;
            vt_addr_reg      <= vt_addr_next;
            vt_data_reg      <= vt_data_next;
            wr_ack_reg       <= wr_ack_next;
            clear_done_reg   <= clear_done_next;
        end
    end

    assign vt_en_o      = vt_en_reg;
    assign vt_wr_en_o   = vt_en_reg;
    assign vt_data_o    = vt_data_reg;
    assign wr_ack_o     = wr_ack_reg;
    assign clear_done_o = clear_done_reg;
    assign clear_busy_o = (state_reg == CLEAR) || (state_reg == DONE);

endmodule

// File: tb/tb_vt_write_arbiter.sv
// Directed bench for vt_write_arbiter: a wide instance for arbitration and a
// narrow-address instance for short clear sweeps, both driven by shared stimulus.
module tb_vt_write_arbiter;

    localparam int TW  = 4;
    localparam int VW  = 11;
    localparam int VWS = 3;
    localparam int CS  = 40;
    localparam int CSS = 2;
    localparam int NR  = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*TW-1:0]  req_thread;
    logic [NR*VW-1:0]  req_var;
    logic [NR*VWS-1:0] req_var_s;
    logic [NR-1:0]     req_data;
    logic              rd_busy;
    logic              clear_start;
    logic [TW-1:0]     clear_thread;

    logic [NR-1:0]          ready_a, ack_a, ready_b, ack_b;
    logic                   cbusy_a, cdone_a, en_a, wen_a, data_a;
    logic                   cbusy_b, cdone_b, en_b, wen_b, data_b;
    logic [CS*(TW+VW)-1:0]   addr_a;
    logic [CSS*(TW+VWS)-1:0] addr_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NR; gi++) begin : g_var_s
            assign req_var_s[gi*VWS +: VWS] = req_var[gi*VW +: VWS];
        end
    endgenerate

    vt_write_arbiter #(
        .VARIABLE_ADDRESS_WIDTH(VW), .THREAD_ID_WIDTH(TW), .CLUSTER_SIZE(CS), .NUM_REQ(NR)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(ready_a),
        .req_thread_mi(req_thread), .req_var_mi(req_var), .req_data_i(req_data),
        .rd_busy_i(rd_busy), .clear_start_i(clear_start), .clear_thread_i(clear_thread),
        .clear_busy_o(cbusy_a), .clear_done_o(cdone_a), .vt_en_o(en_a), .vt_wr_en_o(wen_a),
        .vt_addr_mo(addr_a), .vt_data_o(data_a), .wr_ack_o(ack_a)
    );

    vt_write_arbiter #(
        .VARIABLE_ADDRESS_WIDTH(VWS), .THREAD_ID_WIDTH(TW), .CLUSTER_SIZE(CSS), .NUM_REQ(NR)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(ready_b),
        .req_thread_mi(req_thread), .req_var_mi(req_var_s), .req_data_i(req_data),
        .rd_busy_i(rd_busy), .clear_start_i(clear_start), .clear_thread_i(clear_thread),
        .clear_busy_o(cbusy_b), .clear_done_o(cdone_b), .vt_en_o(en_b), .vt_wr_en_o(wen_b),
        .vt_addr_mo(addr_b), .vt_data_o(data_b), .wr_ack_o(ack_b)
    );

    typedef struct {
        logic [NR-1:0] valid;
        logic          busy;
        logic [NR-1:0] exp_ready;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];
    logic [TW+VW-1:0] exp_pay_addr [NR];
    logic             exp_pay_data [NR];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic int oh_idx(input logic [NR-1:0] v);
        int r = 0;
        for (int i = 0; i < NR; i++) if (v[i]) r = i;
        return r;
    endfunction

    logic [NR-1:0] prev_ready;
    int            idx, strobes, dones, done_k;

    initial begin
        rst_n = 1'b0; req_valid = '0; rd_busy = 1'b0; clear_start = 1'b0; clear_thread = '0;
        req_thread = {4'hC, 4'h7, 4'hA, 4'h3};
        req_var    = {11'h001, 11'h7FF, 11'h2AA, 11'h155};
        req_data   = 4'b0101;
        exp_pay_addr[0] = {4'h3, 11'h155}; exp_pay_data[0] = 1'b1;
        exp_pay_addr[1] = {4'hA, 11'h2AA}; exp_pay_data[1] = 1'b0;
        exp_pay_addr[2] = {4'h7, 11'h7FF}; exp_pay_data[2] = 1'b1;
        exp_pay_addr[3] = {4'hC, 11'h001}; exp_pay_data[3] = 1'b0;

        // idle, single grant, rotation through all four, read hold-off, wrap-around
        vecs[0]  = '{4'b0000, 1'b0, 4'b0000};
        vecs[1]  = '{4'b0001, 1'b0, 4'b0001};
        vecs[2]  = '{4'b0000, 1'b0, 4'b0000};
        vecs[3]  = '{4'b1111, 1'b0, 4'b0010};
        vecs[4]  = '{4'b1111, 1'b0, 4'b0100};
        vecs[5]  = '{4'b1111, 1'b0, 4'b1000};
        vecs[6]  = '{4'b1111, 1'b0, 4'b0001};
        vecs[7]  = '{4'b0000, 1'b0, 4'b0000};
        vecs[8]  = '{4'b0100, 1'b1, 4'b0000};
        vecs[9]  = '{4'b0100, 1'b1, 4'b0000};
        vecs[10] = '{4'b0100, 1'b1, 4'b0000};
        vecs[11] = '{4'b0100, 1'b1, 4'b0000};
        vecs[12] = '{4'b0100, 1'b1, 4'b0000};
        vecs[13] = '{4'b0100, 1'b0, 4'b0100};
        vecs[14] = '{4'b0000, 1'b0, 4'b0000};
        vecs[15] = '{4'b0011, 1'b0, 4'b0001};
        vecs[16] = '{4'b0011, 1'b0, 4'b0010};
        vecs[17] = '{4'b0011, 1'b0, 4'b0001};
        vecs[18] = '{4'b0000, 1'b0, 4'b0000};

        // reset hold and quiet release
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_en", en_a, 0);
        check("rst_ack", ack_a, 0);
        check("rst_data", data_a, 0);
        check("rst_addr", (addr_a == '0), 1);
        check("rst_done", cdone_a, 0);
        check("rst_busy", cbusy_a, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            check($sformatf("quiet%0d_en", c), en_a, 0);
            check($sformatf("quiet%0d_ack", c), ack_a, 0);
        end

        // asynchronous reset in the middle of traffic
        @(negedge clk); req_valid = 4'b1111;
        @(posedge clk); #1;
        check("pre_rst_en", en_a, 1);
        check("pre_rst_data", data_a, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_en", en_a, 0);
        check("async_rst_wen", wen_a, 0);
        check("async_rst_ack", ack_a, 0);
        check("async_rst_data", data_a, 0);
        check("async_rst_addr", (addr_a == '0), 1);
        @(negedge clk); req_valid = '0; rst_n = 1'b1;

        prev_ready = '0;
        for (int r = 0; r < NVEC; r++) begin
            @(negedge clk);
            req_valid = vecs[r].valid;
            rd_busy   = vecs[r].busy;
            #1;
            check($sformatf("v%0d_ready", r), ready_a, vecs[r].exp_ready);
            check($sformatf("v%0d_en", r), en_a, (prev_ready != 0));
            check($sformatf("v%0d_wen", r), wen_a, (prev_ready != 0));
            check($sformatf("v%0d_ack", r), ack_a, prev_ready);
            if (prev_ready != 0) begin
                idx = oh_idx(prev_ready);
                check($sformatf("v%0d_addr", r), addr_a[TW+VW-1:0], exp_pay_addr[idx]);
                check($sformatf("v%0d_addr_repl", r), (addr_a == {CS{exp_pay_addr[idx]}}), 1);
                check($sformatf("v%0d_data", r), data_a, exp_pay_data[idx]);
            end
            prev_ready = vecs[r].exp_ready;
        end

        // clear sweep on the narrow instance, read hold-off for two cycles mid-sweep
        @(negedge clk);
        rd_busy = 1'b0; clear_start = 1'b1; clear_thread = 4'd5; req_valid = 4'b0010;
        #1;
        check("clr_wins_ready_b", ready_b, 0);
        check("clr_wins_ready_a", ready_a, 0);
        strobes = 0; dones = 0; done_k = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            clear_start = 1'b0;
            rd_busy = (k == 4 || k == 5);
            #1;
            if (k <= 11) begin
                check($sformatf("sweep%0d_ready", k), ready_b, 0);
                check($sformatf("sweep%0d_busy", k), cbusy_b, 1);
            end else begin
                check("post_sweep_ready", ready_b, 4'b0010);
                check("post_sweep_busy", cbusy_b, 0);
            end
            if (en_b) begin
                check($sformatf("sweep_w%0d_addr", strobes), addr_b[TW+VWS-1:0],
                      {4'd5, 3'(strobes)});
                check($sformatf("sweep_w%0d_data", strobes), data_b, 0);
                strobes++;
            end
            if (cdone_b) begin
                dones++;
                done_k = k;
            end
        end
        check("sweep_strobes", strobes, 8);
        check("sweep_dones", dones, 1);
        check("sweep_done_cycle", done_k, 11);
        @(negedge clk); req_valid = '0; #1;
        check("post_sweep_ack", ack_b, 4'b0010);
        check("post_sweep_en", en_b, 1);
        check("post_sweep_addr", addr_b[TW+VWS-1:0], {4'hA, 3'b010});

        // clear and request together, then reset part-way through the sweep
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        clear_start = 1'b1; clear_thread = 4'd9; req_valid = 4'b0001;
        #1;
        check("clr_req_ready_a", ready_a, 0);
        check("clr_req_ready_b", ready_b, 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); clear_start = 1'b0; #1;
            check($sformatf("s6_%0d_busy", k), cbusy_a, 1);
            check($sformatf("s6_%0d_ready", k), ready_a, 0);
            if (k >= 2) begin
                check($sformatf("s6_%0d_en", k), en_a, 1);
                check($sformatf("s6_%0d_addr", k), addr_a[TW+VW-1:0], {4'd9, 11'(k-2)});
            end
        end
        #1 rst_n = 1'b0;
        #1;
        check("s6_rst_en", en_a, 0);
        check("s6_rst_busy", cbusy_a, 0);
        check("s6_rst_done", cdone_a, 0);
        @(negedge clk); rst_n = 1'b1; #1;
        check("s6_after_rst_ready", ready_a, 4'b0001);
        @(negedge clk); req_valid = '0; #1;
        check("s6_after_rst_ack", ack_a, 4'b0001);
        check("s6_after_rst_en", en_a, 1);
        check("s6_after_rst_addr", addr_a[TW+VW-1:0], {4'h3, 11'h155});
        check("s6_after_rst_data", data_a, 1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #1;
            check($sformatf("s6_nodone%0d_a", c), cdone_a, 0);
            check($sformatf("s6_nodone%0d_b", c), cdone_b, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
